// File: rtl/acc_proc_if.sv
// Operator, program-load and status signals of the accumulator processor.
interface acc_proc_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
);
   // No valid/ready pair here: ProgWr is a write strobe qualified by ProgEn on
   // the same edge, and Enter is a level whose 0->1 transition is consumed only
   // while WaitIn=1; an edge seen in any other state is dropped, never queued.
   logic              ProgEn;
   logic              ProgWr;
   logic [ADDR_W-1:0] ProgAddr;
   logic [DATA_W-1:0] ProgData;
   logic              Enter;
   logic [DATA_W-1:0] Input;
   logic [DATA_W-1:0] Output;
   logic              Halt;
   logic              WaitIn;
   logic [ADDR_W-1:0] Pc;
   logic [1:0]        dbg_state;

   modport master (
      output ProgEn, ProgWr, ProgAddr, ProgData, Enter, Input,
      input  Output, Halt, WaitIn, Pc, dbg_state
   );

   modport slave (
      input  ProgEn, ProgWr, ProgAddr, ProgData, Enter, Input,
      output Output, Halt, WaitIn, Pc, dbg_state
   );
endinterface

// File: rtl/acc_proc.sv
// Single-accumulator processor: 8 opcodes, register-array program/data memory,
// operator input handshake via an Enter rising edge, and a program-load mode.
module acc_proc #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
) (
   input logic      Clock,
   input logic      Reset,
   acc_proc_if.slave bus
);
   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      EXEC    = 2'd1,
      WAIT_IN = 2'd2,
      HALTED  = 2'd3
   } state_t;

   localparam logic [2:0] OP_LOAD  = 3'b000;
   localparam logic [2:0] OP_STORE = 3'b001;
   localparam logic [2:0] OP_ADD   = 3'b010;
   localparam logic [2:0] OP_SUB   = 3'b011;
   localparam logic [2:0] OP_IN    = 3'b100;
   localparam logic [2:0] OP_JZ    = 3'b101;
   localparam logic [2:0] OP_JPOS  = 3'b110;
   localparam logic [2:0] OP_HALT  = 3'b111;

   state_t            state;
   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] ir;
   logic [ADDR_W-1:0] pc;
   logic              enter_q;
   logic [DATA_W-1:0] mem [2**ADDR_W];

   logic [2:0]        opcode;
   logic [ADDR_W-1:0] operand;
   logic [DATA_W-1:0] mem_op;
   logic              enter_rise;

   assign opcode     = ir[DATA_W-1 -: 3];
   assign operand    = ir[ADDR_W-1:0];
   assign mem_op     = mem[operand];
   assign enter_rise = bus.Enter & ~enter_q;

   // Memory is never cleared by Reset; Reset only blocks writes on its edge.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         if (bus.ProgEn) begin
            if (bus.ProgWr) mem[bus.ProgAddr] <= bus.ProgData;
         end else if (state == EXEC && opcode == OP_STORE) begin
            mem[operand] <= acc;
         end
      end
   end

   always_ff @(posedge Clock) begin
      // Sampled every cycle, including reset, so a held Enter is not an edge.
      enter_q <= bus.Enter;
      if (Reset) begin
         state <= FETCH;
         acc   <= '0;
         ir    <= '0;
         pc    <= '0;
      end else if (bus.ProgEn) begin
         state <= FETCH;
         pc    <= '0;
      end else begin
         case (state)
            FETCH: begin
               ir    <= mem[pc];
               pc    <= pc + ADDR_W'(1);
               state <= EXEC;
            end
            EXEC: begin
               state <= FETCH;
               case (opcode)
                  OP_LOAD:  acc <= mem_op;
                  OP_STORE: ;
                  OP_ADD:   acc <= acc + mem_op;
                  OP_SUB:   acc <= acc - mem_op;
                  OP_IN:    state <= WAIT_IN;
                  OP_JZ:    if (acc == '0) pc <= operand;
                  OP_JPOS:  if (acc != '0 && !acc[DATA_W-1]) pc <= operand;
                  OP_HALT:  state <= HALTED;
                  default:  ;
               endcase
            end
            WAIT_IN: begin
               if (enter_rise) begin
                  acc   <= bus.Input;
                  state <= FETCH;
               end
            end
            HALTED: ;
            default: state <= FETCH;
         endcase
      end
   end

   assign bus.Output    = acc;
   assign bus.Pc        = pc;
   assign bus.Halt      = (state == HALTED);
   assign bus.WaitIn    = (state == WAIT_IN);
   assign bus.dbg_state = state;
endmodule

// File: tb/tb_acc_proc.sv
// Self-checking bench for acc_proc: directed programs plus randomized runs,
// compared every cycle against an architectural model of the processor.
module tb_acc_proc;
   localparam int DW    = 8;
   localparam int AW    = 5;
   localparam int DEPTH = 32;

   localparam int M_FETCH = 0;
   localparam int M_EXEC  = 1;
   localparam int M_WAIT  = 2;
   localparam int M_HALT  = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   acc_proc_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   acc_proc #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .Clock (clk),
      .Reset (rst),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   int m_mem [DEPTH];
   int m_a, m_ir, m_pc, m_mode;
   bit m_enter_prev;

   logic [7:0] img [DEPTH];

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Architectural model: what each clock edge must do, written per instruction.
   task automatic model_step();
      int  op, adr;
      bit  rise;
      rise = bus.Enter && !m_enter_prev;
      m_enter_prev = bus.Enter;
      if (rst) begin
         m_a = 0; m_ir = 0; m_pc = 0; m_mode = M_FETCH;
      end else if (bus.ProgEn) begin
         if (bus.ProgWr) m_mem[int'(bus.ProgAddr)] = int'(bus.ProgData);
         m_pc = 0;
         m_mode = M_FETCH;
      end else if (m_mode == M_FETCH) begin
         m_ir = m_mem[m_pc];
         m_pc = (m_pc + 1) % DEPTH;
         m_mode = M_EXEC;
      end else if (m_mode == M_EXEC) begin
         op  = m_ir / 32;
         adr = m_ir % 32;
         m_mode = M_FETCH;
         case (op)
            0: m_a = m_mem[adr];
            1: m_mem[adr] = m_a;
            2: m_a = (m_a + m_mem[adr]) % 256;
            3: m_a = (m_a - m_mem[adr] + 256) % 256;
            4: m_mode = M_WAIT;
            5: if (m_a == 0) m_pc = adr;
            6: if (m_a != 0 && m_a < 128) m_pc = adr;
            default: m_mode = M_HALT;
         endcase
      end else if (m_mode == M_WAIT) begin
         if (rise) begin
            m_a = int'(bus.Input);
            m_mode = M_FETCH;
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            check("output",  32'(bus.Output), 32'(m_a));
            check("pc",      32'(bus.Pc),     32'(m_pc));
            check("halt",    32'(bus.Halt),   32'(m_mode == M_HALT));
            check("wait_in", 32'(bus.WaitIn), 32'(m_mode == M_WAIT));
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_img();
      for (int i = 0; i < DEPTH; i++) img[i] = 8'h00;
   endtask

   task automatic load_img();
      bus.ProgEn = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         bus.ProgWr   = 1'b1;
         bus.ProgAddr = AW'(i);
         bus.ProgData = img[i];
         step(1);
      end
      bus.ProgWr = 1'b0;
      bus.ProgEn = 1'b0;
   endtask

   task automatic wait_flag(input int which, input int budget, input string name);
      int n = 0;
      while (!(which == 0 ? bus.Halt : bus.WaitIn) && n < budget) begin
         step(1);
         n++;
      end
      check(name, 32'(which == 0 ? bus.Halt : bus.WaitIn), 32'd1);
   endtask

   task automatic wait_pc(input int value, input int budget);
      int n = 0;
      while (int'(bus.Pc) != value && n < budget) begin
         step(1);
         n++;
      end
      check("wait_pc", 32'(bus.Pc), 32'(value));
   endtask

   initial begin
      bus.ProgEn = 1'b0; bus.ProgWr = 1'b0; bus.ProgAddr = '0; bus.ProgData = '0;
      bus.Enter = 1'b0;  bus.Input = '0;
      rst = 1'b1;
      step(1);
      chk_en = 1'b1;
      check("rst_output", 32'(bus.Output), 32'h0);
      check("rst_pc",     32'(bus.Pc),     32'h0);
      check("rst_halt",   32'(bus.Halt),   32'h0);
      check("rst_waitin", 32'(bus.WaitIn), 32'h0);
      rst = 1'b0;

      // Wrapping ADD: 0xF0 + 0x20 = 0x10, stored and reloaded.
      clear_img();
      img[0] = 8'h0A; img[1] = 8'h4B; img[2] = 8'h2C; img[3] = 8'h0C; img[4] = 8'hE0;
      img[10] = 8'hF0; img[11] = 8'h20;
      load_img();
      wait_flag(0, 60, "add_halt");
      check("add_output", 32'(bus.Output), 32'h10);
      check("add_pc",     32'(bus.Pc),     32'd5);

      // JPOS on negative not taken, SUB to zero, JZ taken.
      clear_img();
      img[0] = 8'h0A; img[1] = 8'hC5; img[2] = 8'h6A; img[3] = 8'hA6;
      img[4] = 8'hE0; img[5] = 8'hE0; img[6] = 8'hE0; img[10] = 8'h80;
      load_img();
      wait_flag(0, 60, "jmp_halt");
      check("jmp_output", 32'(bus.Output), 32'h00);
      check("jmp_pc",     32'(bus.Pc),     32'd7);

      // IN waits indefinitely without an Enter edge.
      clear_img();
      img[0] = 8'h80; img[1] = 8'hE0;
      bus.Input = 8'h2A;
      load_img();
      wait_flag(1, 10, "in_wait");
      step(25);
      check("in_still_wait", 32'(bus.WaitIn), 32'd1);
      bus.Enter = 1'b1;
      step(1);
      bus.Enter = 1'b0;
      check("in_output", 32'(bus.Output), 32'h2A);
      wait_flag(0, 10, "in_halt");

      // Enter held high through reset is not an edge.
      bus.Enter = 1'b1;
      bus.Input = 8'h55;
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(20);
      check("held_waitin", 32'(bus.WaitIn), 32'd1);
      check("held_output", 32'(bus.Output), 32'h00);
      bus.Enter = 1'b0;
      step(1);
      bus.Enter = 1'b1;
      step(1);
      check("reedge_output", 32'(bus.Output), 32'h55);
      bus.Enter = 1'b0;
      wait_flag(0, 10, "reedge_halt");

      // An edge during FETCH is discarded.
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      bus.Enter = 1'b1;
      step(1);
      bus.Enter = 1'b0;
      step(10);
      check("fetch_edge_waitin", 32'(bus.WaitIn), 32'd1);
      bus.Enter = 1'b1;
      step(1);
      bus.Enter = 1'b0;
      wait_flag(0, 10, "fetch_edge_halt");

      // Reset in the EXEC cycle of an ADD.
      clear_img();
      img[0] = 8'h03; img[1] = 8'h44; img[2] = 8'hE0; img[3] = 8'h11; img[4] = 8'h22;
      load_img();
      step(3);
      rst = 1'b1;
      step(1);
      check("midadd_output", 32'(bus.Output), 32'h00);
      check("midadd_pc",     32'(bus.Pc),     32'h0);
      check("midadd_halt",   32'(bus.Halt),   32'h0);
      check("midadd_waitin", 32'(bus.WaitIn), 32'h0);
      rst = 1'b0;

      // Pc wraps from 31 to 0 on fetch.
      clear_img();
      load_img();
      wait_pc(31, 80);
      step(2);
      check("wrap_pc", 32'(bus.Pc), 32'h0);

      // ProgEn releases HALTED; ProgWr alone is ignored.
      clear_img();
      img[0] = 8'hE0;
      load_img();
      wait_flag(0, 10, "prog_halt");
      bus.ProgEn = 1'b1;
      step(1);
      check("progen_halt", 32'(bus.Halt), 32'h0);
      check("progen_pc",   32'(bus.Pc),   32'h0);
      bus.ProgEn   = 1'b0;
      bus.ProgWr   = 1'b1;
      bus.ProgAddr = '0;
      bus.ProgData = 8'h00;
      step(4);
      check("progwr_ignored_halt", 32'(bus.Halt), 32'h1);
      check("progwr_ignored_pc",   32'(bus.Pc),   32'h1);
      bus.ProgWr = 1'b0;

      // Randomized programs with random operator, program-port and reset activity.
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < DEPTH; i++) begin
            img[i] = 8'($urandom_range(0, 255));
            if (img[i][7:5] == 3'b111 && $urandom_range(0, 3) != 0) img[i][7:5] = 3'b010;
         end
         load_img();
         for (int c = 0; c < 400; c++) begin
            bus.Enter    = ($urandom_range(0, 2) == 0);
            bus.Input    = 8'($urandom_range(0, 255));
            bus.ProgWr   = ($urandom_range(0, 7) == 0);
            bus.ProgAddr = AW'($urandom_range(0, DEPTH - 1));
            bus.ProgData = 8'($urandom_range(0, 255));
            rst          = ($urandom_range(0, 149) == 0);
            bus.ProgEn   = ($urandom_range(0, 99) == 0) ||
                           (m_mode == M_HALT && $urandom_range(0, 9) == 0);
            step(1);
         end
         rst = 1'b0;
         bus.ProgEn = 1'b0;
         bus.ProgWr = 1'b0;
         bus.Enter  = 1'b0;
      end

      step(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
